// File: rtl/jam_dual_sched.sv
// Scheduler for two permutation-evaluation engines: shared cost-port arbiter and result merge.
// Optional watchdog timeout enabled by defining JAM_SCHED_WDOG_EN.
module jam_dual_sched #(
    parameter int unsigned BURST      = 8,
    parameter logic [15:0] WDOG_LIMIT = 16'd4095
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    output logic       eng_start,
    output logic       busy,
    input  logic       e0_req,
    input  logic       e1_req,
    input  logic [2:0] e0_W,
    input  logic [2:0] e0_J,
    input  logic [2:0] e1_W,
    input  logic [2:0] e1_J,
    output logic       e0_gnt,
    output logic       e1_gnt,
    output logic       e0_rvalid,
    output logic       e1_rvalid,
    output logic [6:0] e0_Cost,
    output logic [6:0] e1_Cost,
    input  logic       e0_done,
    input  logic       e1_done,
    input  logic [9:0] e0_min,
    input  logic [9:0] e1_min,
    input  logic [3:0] e0_cnt,
    input  logic [3:0] e1_cnt,
    output logic [2:0] W,
    output logic [2:0] J,
    input  logic [6:0] Cost,
    output logic [9:0] MinCost,
    output logic [4:0] MatchCount,
    output logic       Valid,
    output logic       Err
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MERGE, S_DONE} state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic          last_e1;
    logic          d0, d1;
    logic [9:0]    r0_min, r1_min;
    logic [3:0]    r0_cnt, r1_cnt;

    logic          run, beat0, beat1, burst_end;
    logic          cap0, cap1, d0_nxt, d1_nxt, elig0, elig1;
    logic          wdog_hit, go_merge;
    logic [14:0]   merged;

    // Lower minimum wins; a tie keeps the shared minimum and sums the match counts.
    function automatic logic [14:0] merge_res(input logic [9:0] m0, input logic [3:0] c0,
                                              input logic [9:0] m1, input logic [3:0] c1);
        if (m0 < m1)
            return {m0, 1'b0, c0};
        else if (m0 > m1)
            return {m1, 1'b0, c1};
        else
            return {m0, {1'b0, c0} + {1'b0, c1}};
    endfunction

    assign run       = (state == S_RUN);
    assign beat0     = run && e0_gnt && e0_req;
    assign beat1     = run && e1_gnt && e1_req;
    assign burst_end = (beat0 || beat1) && (beat_cnt == LAST_BEAT);
    assign cap0      = run && e0_done && !d0;
    assign cap1      = run && e1_done && !d1;
    assign d0_nxt    = d0 || (run && e0_done);
    assign d1_nxt    = d1 || (run && e1_done);
    assign elig0     = e0_req && !d0_nxt;
    assign elig1     = e1_req && !d1_nxt;
    assign go_merge  = run && ((d0_nxt && d1_nxt) || wdog_hit);
    assign merged    = merge_res(r0_min, r0_cnt, r1_min, r1_cnt);

    assign e0_Cost = Cost;
    assign e1_Cost = Cost;

    always_comb begin
        W = 3'd0;
        J = 3'd0;
        if (beat0) begin
            W = e0_W;
            J = e0_J;
        end else if (beat1) begin
            W = e1_W;
            J = e1_J;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            eng_start  <= 1'b0;
            busy       <= 1'b0;
            Valid      <= 1'b0;
            e0_gnt     <= 1'b0;
            e1_gnt     <= 1'b0;
            e0_rvalid  <= 1'b0;
            e1_rvalid  <= 1'b0;
            beat_cnt   <= '0;
            last_e1    <= 1'b1;
            d0         <= 1'b0;
            d1         <= 1'b0;
            r0_min     <= 10'd1023;
            r1_min     <= 10'd1023;
            r0_cnt     <= 4'd0;
            r1_cnt     <= 4'd0;
            MinCost    <= 10'd1023;
            MatchCount <= 5'd0;
        end else begin
            eng_start <= 1'b0;
            Valid     <= 1'b0;
            // read data returns one cycle after its beat
            e0_rvalid <= beat0;
            e1_rvalid <= beat1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        d0        <= 1'b0;
                        d1        <= 1'b0;
                        r0_min    <= 10'd1023;
                        r1_min    <= 10'd1023;
                        r0_cnt    <= 4'd0;
                        r1_cnt    <= 4'd0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cap0) begin
                        d0     <= 1'b1;
                        r0_min <= e0_min;
                        r0_cnt <= e0_cnt;
                    end
                    if (cap1) begin
                        d1     <= 1'b1;
                        r1_min <= e1_min;
                        r1_cnt <= e1_cnt;
                    end
                    if (go_merge) begin
                        e0_gnt   <= 1'b0;
                        e1_gnt   <= 1'b0;
                        beat_cnt <= '0;
                        state    <= S_MERGE;
                    end else if (e0_gnt) begin
                        if (d0_nxt) begin
                            e0_gnt   <= 1'b0;
                            beat_cnt <= '0;
                        end else if (beat0) begin
                            if (burst_end) begin
                                beat_cnt <= '0;
                                e0_gnt   <= 1'b0;
                                if (elig1) begin
                                    e1_gnt  <= 1'b1;
                                    last_e1 <= 1'b1;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + BW'(1);
                            end
                        end
                    end else if (e1_gnt) begin
                        if (d1_nxt) begin
                            e1_gnt   <= 1'b0;
                            beat_cnt <= '0;
                        end else if (beat1) begin
                            if (burst_end) begin
                                beat_cnt <= '0;
                                e1_gnt   <= 1'b0;
                                if (elig0) begin
                                    e0_gnt  <= 1'b1;
                                    last_e1 <= 1'b0;
                                end
                            end else begin
                                beat_cnt <= beat_cnt + BW'(1);
                            end
                        end
                    end else if (elig0 && (!elig1 || last_e1)) begin
                        e0_gnt  <= 1'b1;
                        last_e1 <= 1'b0;
                    end else if (elig1) begin
                        e1_gnt  <= 1'b1;
                        last_e1 <= 1'b1;
                    end
                end
                S_MERGE: begin
                    {MinCost, MatchCount} <= merged;
                    Valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JAM_SCHED_WDOG_EN
    logic [15:0] wdog_cnt;
    logic        err_q;

    assign wdog_hit = run && (wdog_cnt == WDOG_LIMIT);
    assign Err      = err_q;

    // Any sign of progress restarts the idle count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdog_cnt <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && start)
                err_q <= 1'b0;
            else if (wdog_hit)
                err_q <= 1'b1;
            if (!run || eng_start || beat0 || beat1 || cap0 || cap1)
                wdog_cnt <= 16'd0;
            else
                wdog_cnt <= wdog_cnt + 16'd1;
        end
    end
`else
    logic wdog_unused;
    assign wdog_unused = ^WDOG_LIMIT;
    assign wdog_hit    = 1'b0;
    assign Err         = 1'b0;
`endif

endmodule

// File: tb/tb_jam_dual_sched.sv
// Directed bench for jam_dual_sched: reset, bursts, round-robin, merge cases, reset abort, timeout.
module tb_jam_dual_sched;

    logic       CLK = 1'b0;
    logic       RST, start, eng_start, busy;
    logic       e0_req, e1_req, e0_gnt, e1_gnt, e0_rvalid, e1_rvalid;
    logic [2:0] e0_W, e0_J, e1_W, e1_J, W, J;
    logic [6:0] e0_Cost, e1_Cost, Cost;
    logic       e0_done, e1_done;
    logic [9:0] e0_min, e1_min, MinCost;
    logic [3:0] e0_cnt, e1_cnt;
    logic [4:0] MatchCount;
    logic       Valid, Err;

    int vecs = 0;
    int errs = 0;
    int n_rv;
    int seen;

    jam_dual_sched #(.BURST(8), .WDOG_LIMIT(16'd20)) dut (
        .CLK(CLK), .RST(RST), .start(start), .eng_start(eng_start), .busy(busy),
        .e0_req(e0_req), .e1_req(e1_req),
        .e0_W(e0_W), .e0_J(e0_J), .e1_W(e1_W), .e1_J(e1_J),
        .e0_gnt(e0_gnt), .e1_gnt(e1_gnt),
        .e0_rvalid(e0_rvalid), .e1_rvalid(e1_rvalid),
        .e0_Cost(e0_Cost), .e1_Cost(e1_Cost),
        .e0_done(e0_done), .e1_done(e1_done),
        .e0_min(e0_min), .e1_min(e1_min), .e0_cnt(e0_cnt), .e1_cnt(e1_cnt),
        .W(W), .J(J), .Cost(Cost),
        .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid), .Err(Err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; e0_req = 1'b0; e1_req = 1'b0;
        e0_W = 3'd0; e0_J = 3'd0; e1_W = 3'd0; e1_J = 3'd0; Cost = 7'd5;
        e0_done = 1'b0; e1_done = 1'b0;
        e0_min = 10'd0; e1_min = 10'd0; e0_cnt = 4'd0; e1_cnt = 4'd0;
        step(); step();

        // reset state
        chk("rst_e0_gnt", 16'(e0_gnt), 16'd0);
        chk("rst_e1_gnt", 16'(e1_gnt), 16'd0);
        chk("rst_rvalid", 16'({e0_rvalid, e1_rvalid}), 16'd0);
        chk("rst_eng_start", 16'(eng_start), 16'd0);
        chk("rst_valid", 16'(Valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_err", 16'(Err), 16'd0);
        chk("rst_WJ", 16'({W, J}), 16'd0);
        chk("rst_mincost", 16'(MinCost), 16'd1023);
        chk("rst_matchcount", 16'(MatchCount), 16'd0);

        RST = 1'b0;
        step();
        start = 1'b1;
        step();
        chk("start_eng_start", 16'(eng_start), 16'd1);
        chk("start_busy", 16'(busy), 16'd1);
        start = 1'b0;
        step();
        chk("eng_start_pulse", 16'(eng_start), 16'd0);
        repeat (4) step();
        chk("idle_run_valid", 16'(Valid), 16'd0);
        chk("idle_run_mincost", 16'(MinCost), 16'd1023);
        chk("idle_run_matchcount", 16'(MatchCount), 16'd0);

        // single engine burst of 8
        e0_req = 1'b1; e0_W = 3'd2; e0_J = 3'd3;
        step();
        n_rv = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            chk("b0_e0_gnt", 16'(e0_gnt), 16'(i <= 8));
            chk("b0_e0_rvalid", 16'(e0_rvalid), 16'(i >= 2 && i <= 9));
            chk("b0_e1_rvalid", 16'(e1_rvalid), 16'd0);
            if (e0_rvalid) begin
                n_rv++;
                chk("b0_e0_cost", 16'(e0_Cost), 16'd5);
            end
            if (i == 1) chk("b0_WJ", 16'({W, J}), 16'({3'd2, 3'd3}));
            if (i == 9) begin
                chk("b0_WJ_idle", 16'({W, J}), 16'd0);
                e0_req = 1'b0;
            end
            step();
        end
        chk("b0_rvalid_count", 16'(n_rv), 16'd8);

        // round-robin from a fresh run, with a one-cycle stall on engine 1
        RST = 1'b1;
        step();
        RST = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        e0_req = 1'b1; e1_req = 1'b1;
        e0_W = 3'd1; e0_J = 3'd1; e1_W = 3'd6; e1_J = 3'd7;
        step();
        for (int r = 1; r <= 18; r++) begin
            e1_req = (r != 10);
            #1;
            chk("rr_e0_gnt", 16'(e0_gnt), 16'((r <= 8) || (r == 18)));
            chk("rr_e1_gnt", 16'(e1_gnt), 16'((r >= 9) && (r <= 17)));
            chk("rr_e0_rvalid", 16'(e0_rvalid), 16'((r >= 2) && (r <= 9)));
            chk("rr_e1_rvalid", 16'(e1_rvalid), 16'((r == 10) || (r >= 12)));
            if (r <= 8 || r == 18) chk("rr_W", 16'(W), 16'd1);
            else if (r == 10)      chk("rr_W_stall", 16'(W), 16'd0);
            else                   chk("rr_W", 16'(W), 16'd6);
            step();
        end

        // equal minimum: counts add
        e0_req = 1'b0; e1_req = 1'b0;
        e0_done = 1'b1; e0_min = 10'd300; e0_cnt = 4'd2;
        step();
        e0_done = 1'b0;
        chk("done_drops_gnt", 16'(e0_gnt), 16'd0);
        step();
        e1_done = 1'b1; e1_min = 10'd300; e1_cnt = 4'd3;
        step();
        e1_done = 1'b0;
        chk("merge_busy", 16'(busy), 16'd1);
        chk("merge_valid", 16'(Valid), 16'd0);
        step();
        chk("eq_valid", 16'(Valid), 16'd1);
        chk("eq_mincost", 16'(MinCost), 16'd300);
        chk("eq_matchcount", 16'(MatchCount), 16'd5);
        chk("eq_busy", 16'(busy), 16'd0);
        step();
        chk("eq_valid_once", 16'(Valid), 16'd0);
        chk("eq_mincost_hold", 16'(MinCost), 16'd300);

        // engine 1 lower; start ignored outside IDLE
        start = 1'b1;
        step();
        chk("s5_eng_start", 16'(eng_start), 16'd1);
        start = 1'b0;
        e0_done = 1'b1; e0_min = 10'd412; e0_cnt = 4'd1;
        e1_done = 1'b1; e1_min = 10'd390; e1_cnt = 4'd4;
        step();
        e0_done = 1'b0; e1_done = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("s5_start_ignored", 16'(eng_start), 16'd0);
        chk("s5_valid", 16'(Valid), 16'd1);
        chk("s5_mincost", 16'(MinCost), 16'd390);
        chk("s5_matchcount", 16'(MatchCount), 16'd4);
        step();

        // engine 0 lower, done on different cycles
        start = 1'b1;
        step();
        start = 1'b0;
        e0_done = 1'b1; e0_min = 10'd100; e0_cnt = 4'd7;
        step();
        e0_done = 1'b0;
        e1_done = 1'b1; e1_min = 10'd200; e1_cnt = 4'd1;
        step();
        e1_done = 1'b0;
        step();
        chk("lt_valid", 16'(Valid), 16'd1);
        chk("lt_mincost", 16'(MinCost), 16'd100);
        chk("lt_matchcount", 16'(MatchCount), 16'd7);
        step();

        // reset in the middle of a burst
        start = 1'b1;
        step();
        start = 1'b0;
        e0_req = 1'b1; e0_W = 3'd5; e0_J = 3'd4;
        step();
        step();
        chk("mid_e0_gnt", 16'(e0_gnt), 16'd1);
        chk("mid_e0_rvalid", 16'(e0_rvalid), 16'd1);
        RST = 1'b1;
        step();
        chk("rr_rst_gnt", 16'({e0_gnt, e1_gnt}), 16'd0);
        chk("rr_rst_rvalid", 16'(e0_rvalid), 16'd0);
        chk("rr_rst_busy", 16'(busy), 16'd0);
        chk("rr_rst_mincost", 16'(MinCost), 16'd1023);
        chk("rr_rst_matchcount", 16'(MatchCount), 16'd0);
        chk("rr_rst_WJ", 16'({W, J}), 16'd0);
        RST = 1'b0;
        step();
        chk("post_rst_idle_gnt", 16'(e0_gnt), 16'd0);
        e0_req = 1'b0;
        step();

        // one engine silent
        start = 1'b1;
        step();
        start = 1'b0;
        e0_done = 1'b1; e0_min = 10'd250; e0_cnt = 4'd1;
        e1_min = 10'd10; e1_cnt = 4'd9;
        step();
        e0_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (Valid) seen = 1;
            if (seen == 1) break;
            step();
        end
`ifdef JAM_SCHED_WDOG_EN
        chk("wd_valid_seen", 16'(seen), 16'd1);
        chk("wd_err", 16'(Err), 16'd1);
        chk("wd_mincost", 16'(MinCost), 16'd250);
        chk("wd_matchcount", 16'(MatchCount), 16'd1);
`else
        chk("nowd_valid_seen", 16'(seen), 16'd0);
        chk("nowd_err", 16'(Err), 16'd0);
        chk("nowd_busy", 16'(busy), 16'd1);
`endif
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/jam_dual_sched.md
Name: jam_dual_sched

Overview:
- Scheduler for a two-engine job-assignment search.
- Starts both permutation-evaluation engines together. Engine 0 covers permutations whose first worker is 0..3; engine 1 covers 4..7. The split is fixed inside the engines.
- Arbitrates the single shared cost-table read port between the engines, in bursts of one full permutation.
- When both engines finish, merges their (MinCost, MatchCount) results and pulses Valid.

Parameters:
- BURST, 8, cost reads granted per ownership period (one permutation = 8 worker/job pairs)
- WDOG_LIMIT, 16'd4095, idle-cycle limit for the watchdog (used only with JAM_SCHED_WDOG_EN)

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a search; honoured only in IDLE
- eng_start  out  1  one-cycle pulse to both engines
- busy  out  1  high in RUN and MERGE
- e0_req / e1_req  in  1  engine requests the cost port
- e0_W, e0_J / e1_W, e1_J  in  3 each  worker/job address from the engine
- e0_gnt / e1_gnt  out  1  engine owns the cost port (registered)
- e0_rvalid / e1_rvalid  out  1  returned cost is valid for that engine
- e0_Cost / e1_Cost  out  7  returned cost, shared copy of Cost
- e0_done / e1_done  in  1  engine finished; its result inputs are stable from this cycle
- e0_min / e1_min  in  10  engine minimum cost
- e0_cnt / e1_cnt  in  4  engine match count
- W  out  3  cost-table worker address
- J  out  3  cost-table job address
- Cost  in  7  cost-table data, valid one cycle after W/J
- MinCost  out  10  merged minimum
- MatchCount  out  5  merged match count
- Valid  out  1  one-cycle result pulse
- Err  out  1  watchdog timeout flag

Behaviour:
- Reset values:
  - gnt, rvalid, eng_start, Valid, busy, Err: 0
  - W, J: 0
  - MinCost: 1023; MatchCount: 0
  - Arbiter owner = NONE; last-served = E1, so E0 wins the first tie.
  - Done flags cleared; FSM in IDLE.
- Reset asserted in any cycle returns everything to these values on that edge, including mid-burst and mid-merge.
- Top FSM:
  - IDLE: on start, pulse eng_start, clear done flags, go to RUN.
  - RUN: run the arbiter. Capture each engine's done flag and result on the cycle its done is high; the flag is sticky. Both flags set (same or different cycles) -> MERGE.
  - MERGE (1 cycle):
    - e0_min < e1_min: take e0_min and e0_cnt.
    - e0_min > e1_min: take e1_min and e1_cnt.
    - Equal: take the shared min; MatchCount = e0_cnt + e1_cnt, zero-extended to 5 bits, no overflow possible.
    - Then go to DONE.
  - DONE: Valid = 1 for exactly one cycle, then IDLE.
  - MinCost and MatchCount hold until the next MERGE. start outside IDLE is ignored.
- Arbiter (active only in RUN):
  - Owner NONE: at the edge, grant a requesting engine. If both request, grant the one not last served. gnt rises the following cycle.
  - A beat is a cycle with req & gnt. W/J = the owner's W/J in a beat, otherwise 0.
  - Owner's rvalid and Cost copy are driven exactly one cycle after each beat. Cost is routed to both eN_Cost buses; only rvalid qualifies it.
  - Beat counter counts 0..BURST-1. A cycle with req low while granted is a stall: no beat, grant held.
  - On the BURST-th beat: if the other engine is requesting, ownership moves directly to it (gnt swaps at that edge, zero bubble). Otherwise owner returns to NONE.
  - An owner whose done is seen while granted loses grant at that edge. An rvalid already in flight is still delivered.
  - A done engine is never granted again in this run.
- Leaving RUN forces owner NONE and all gnt low.

Optional Feature:
- Macro: JAM_SCHED_WDOG_EN.
- With the macro:
  - A 16-bit counter clears on eng_start, on any beat, and on any done capture; otherwise it increments in RUN.
  - When it reaches WDOG_LIMIT: set Err (sticky until start or RST) and go to MERGE.
  - A non-done engine is treated as min = 1023, cnt = 0.
- Without the macro: no counter, Err tied 0, no timeout path.

Test Plan:
- Reset then start -> eng_start pulses at the next edge. Without engine activity, MinCost = 1023 and MatchCount = 0 persist, Valid stays 0.
- e0_req alone held high for 8 beats with Cost = 5 each -> e0_gnt rises 1 cycle after req. Exactly 8 e0_rvalid pulses, each 1 cycle after its beat, with e0_Cost = 5. Owner returns to NONE.
- Both requesting from the first cycle -> E0 gets 8 beats, E1 granted on the edge of E0's 8th beat with no idle cycle, then E0 again (round-robin). A req drop mid-burst stalls without counting a beat.
- e0 done with (min 300, cnt 2), two cycles later e1 done with (min 300, cnt 3) -> MERGE gives MinCost = 300, MatchCount = 5; Valid pulses once.
- Done results e0 (412, 1) and e1 (390, 4) -> MinCost = 390, MatchCount = 4. RST asserted during RUN -> all outputs at reset values on the next cycle.
- With JAM_SCHED_WDOG_EN and WDOG_LIMIT = 20: e0 done (250, 1), e1 silent -> Err = 1, MinCost = 250, MatchCount = 1, Valid pulses. Without the macro the same stimulus never pulses Valid.
